// File: rtl/fetch_controller_pkg.sv
// Shared widths, fetch increment and FSM state encodings for the fetch controller.
package fetch_controller_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] FETCH_INCR = ADDR_W'(4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_controller_buffer.sv
// Synchronous FIFO holding fetched {pc, instr} pairs until decode takes them.
// Flush beats push and pop; push and pop together are legal even when full.
module fetch_controller_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head outputs read zero until the first word lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: issues word addresses, buffers returned words with their PC.
// Optional FETCH_ALIGN_CHECK_EN adds a HALT state and o_fault for misaligned redirects.
//
//   state | meaning
//   RUN   | normal fetch, one issue per cycle while the buffer has room
//   HALT  | misaligned redirect seen; nothing issued until an aligned redirect
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  o_req_addr,
    input  logic [INSTR_W-1:0] i_res_data,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    input  logic               i_ready,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_addr
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               o_fault
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [ADDR_W-1:0]  fetch_pc;
    logic               inflight_v;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               pop;
    logic               issue;
    logic               run;
    logic [ADDR_W-1:0]  target;
    logic [CNT_W:0]     occupancy;
    logic [ADDR_W+INSTR_W-1:0] head;

`ifdef FETCH_ALIGN_CHECK_EN
    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_redirect) begin
            state_next = (i_redirect_addr[1:0] != 2'b00) ? HALT : RUN;
        end
    end

    always_comb begin
        o_fault = (state == HALT);
        run     = (state == RUN);
    end

    assign target = i_redirect_addr;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^i_redirect_addr[1:0];
    assign run              = 1'b1;
    assign target           = {i_redirect_addr[ADDR_W-1:2], 2'b00};
`endif

    assign o_req_addr = fetch_pc;
    assign o_valid    = !empty;
    assign pop        = o_valid && i_ready;

    // Words already owed to the buffer (held + in flight) after this cycle's pop.
    assign occupancy = {1'b0, count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(inflight_v);
    assign issue     = run && !i_redirect && (occupancy < (CNT_W + 1)'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else if (i_redirect) begin
            fetch_pc    <= target;
            inflight_v  <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + FETCH_INCR;
            inflight_v  <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight_v  <= 1'b0;
        end
    end

    fetch_controller_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_v),
        .pop   (pop),
        .flush (i_redirect),
        .din   ({inflight_pc, i_res_data}),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign {o_pc, o_instr} = head;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a PC scoreboard fed at each (re)start of the stream.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [31:0] req_addr;
    logic [31:0] res_data;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_addr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    fetch_controller dut (
        .clk             (clk),
        .reset           (reset),
        .o_req_addr      (req_addr),
        .i_res_data      (res_data),
        .o_valid         (valid),
        .o_instr         (instr),
        .o_pc            (pc),
        .i_ready         (ready),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .o_fault         (fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'h11 * ({2'b00, a[31:2]} + 32'd1);
    endfunction

    // One-cycle synchronous instruction memory.
    always @(posedge clk) res_data <= mem_val(req_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic restart_q(input logic [31:0] a);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(a + 32'(4 * i));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Every accepted beat must be the next PC of the current stream, with matching data.
    always @(negedge clk) begin
        if (!reset && valid && ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("beat_pc", pc, e);
                check("beat_instr", instr, mem_val(e));
            end
        end
    end

    initial begin
        reset = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
        cyc(); cyc();
        neg();
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_fault", {31'b0, fault}, 32'd0);
`endif

        // Startup latency and first beats.
        cyc(); reset = 1'b0; ready = 1'b1; restart_q(32'h0);
        neg(); check("start_c0_valid", {31'b0, valid}, 32'd0);
        cyc(); neg(); check("start_c1_valid", {31'b0, valid}, 32'd0);
        cyc(); neg();
        check("start_c2_valid", {31'b0, valid}, 32'd1);
        check("start_c2_pc", pc, 32'h0);
        check("start_c2_instr", instr, 32'h11);

        // Decode stall for 5 cycles: issue stops at 12, head holds pc 4.
        for (int i = 0; i < 5; i++) begin
            cyc(); ready = 1'b0;
            neg();
            check("stall_req_addr", req_addr, 32'hC);
            check("stall_valid", {31'b0, valid}, 32'd1);
            check("stall_pc", pc, 32'h4);
        end
        cyc(); ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        // Redirect mid-stream with a request in flight.
        cyc(); redirect = 1'b1; redirect_addr = 32'h40; restart_q(32'h40);
        cyc(); redirect = 1'b0;
        neg(); check("redir_n1_valid", {31'b0, valid}, 32'd0);
        cyc(); neg(); check("redir_n2_valid", {31'b0, valid}, 32'd0);
        cyc(); neg();
        check("redir_n3_valid", {31'b0, valid}, 32'd1);
        check("redir_n3_pc", pc, 32'h40);
        check("redir_n3_instr", instr, mem_val(32'h40));
        for (int i = 0; i < 3; i++) cyc();

        // Fill the buffer, then redirect while decode is accepting the head.
        cyc(); ready = 1'b0;
        cyc(); cyc();
        cyc(); ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h80; restart_q(32'h80);
        neg(); check("full_redir_head_shown", {31'b0, valid}, 32'd1);
        cyc(); redirect = 1'b0;
        neg(); check("full_redir_n1_valid", {31'b0, valid}, 32'd0);
        cyc(); neg(); check("full_redir_n2_valid", {31'b0, valid}, 32'd0);
        cyc(); neg();
        check("full_redir_n3_valid", {31'b0, valid}, 32'd1);
        check("full_redir_n3_pc", pc, 32'h80);
        for (int i = 0; i < 4; i++) cyc();

        // One-cycle reset mid-stream restarts at RESET_PC.
        cyc(); reset = 1'b1; restart_q(32'h0);
        cyc(); reset = 1'b0;
        neg(); check("mid_rst_n1_valid", {31'b0, valid}, 32'd0);
        cyc(); neg(); check("mid_rst_n2_valid", {31'b0, valid}, 32'd0);
        cyc(); neg();
        check("mid_rst_n3_valid", {31'b0, valid}, 32'd1);
        check("mid_rst_n3_pc", pc, 32'h0);
        for (int i = 0; i < 3; i++) cyc();

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect halts with a fault; an aligned one recovers.
        cyc(); redirect = 1'b1; redirect_addr = 32'h42; exp_q.delete();
        cyc(); redirect = 1'b0;
        neg();
        check("halt_fault", {31'b0, fault}, 32'd1);
        check("halt_req_addr", req_addr, 32'h42);
        for (int i = 0; i < 3; i++) begin
            cyc(); neg();
            check("halt_valid", {31'b0, valid}, 32'd0);
            check("halt_fault_hold", {31'b0, fault}, 32'd1);
        end
        cyc(); redirect = 1'b1; redirect_addr = 32'h44; restart_q(32'h44);
        cyc(); redirect = 1'b0;
        neg();
        check("recover_fault", {31'b0, fault}, 32'd0);
        check("recover_n1_valid", {31'b0, valid}, 32'd0);
        cyc(); neg(); check("recover_n2_valid", {31'b0, valid}, 32'd0);
        cyc(); neg();
        check("recover_n3_valid", {31'b0, valid}, 32'd1);
        check("recover_n3_pc", pc, 32'h44);
        check("recover_n3_instr", instr, 32'h132);
`else
        // Misaligned redirect target is masked to the word address.
        cyc(); redirect = 1'b1; redirect_addr = 32'h42; restart_q(32'h40);
        cyc(); redirect = 1'b0;
        neg();
        check("mask_req_addr", req_addr, 32'h40);
        check("mask_n1_valid", {31'b0, valid}, 32'd0);
        cyc(); neg(); check("mask_n2_valid", {31'b0, valid}, 32'd0);
        cyc(); neg();
        check("mask_n3_valid", {31'b0, valid}, 32'd1);
        check("mask_n3_pc", pc, 32'h40);
        check("mask_n3_instr", instr, 32'h121);
`endif
        for (int i = 0; i < 4; i++) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
